// File: rtl/nios_project_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port on-chip RAM.
// Grant is combinational; only the round-robin pointer and the read-response tag are registered.
module nios_project_onchip_mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    logic req0_s;
    logic req1_s;
    logic gnt0_s;
    logic gnt1_s;
    logic rd_accept_s;
    logic rr_last_r;
    logic pend_valid_r;
    logic pend_id_r;

    // Request decode and round-robin grant; the requester that did not win last gets priority
    always_comb begin
        req0_s = m0_read | m0_write;
        req1_s = m1_read | m1_write;
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset || reset_req) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case ({req1_s, req0_s})
                2'b01:   gnt0_s = 1'b1;
                2'b10:   gnt1_s = 1'b1;
                2'b11: begin
                    if (rr_last_r) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b1;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // RAM-side steering; with no grant the mux rests on m0 so the address is harmless
    always_comb begin
        if (gnt1_s) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end else begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
        end
        mem_chipselect = gnt0_s | gnt1_s;
        mem_write      = (gnt0_s & m0_write) | (gnt1_s & m1_write);
        mem_clken      = 1'b1;
        m0_waitrequest = ~gnt0_s;
        m1_waitrequest = ~gnt1_s;
        // a simultaneous write wins over read, so only pure reads expect a response
        rd_accept_s    = (gnt0_s & m0_read & ~m0_write) | (gnt1_s & m1_read & ~m1_write);
    end

    // Round-robin pointer and the one-deep tag of the read now in the RAM pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_r    <= 1'b1;
            pend_valid_r <= 1'b0;
            pend_id_r    <= 1'b0;
        end else begin
            if (gnt0_s || gnt1_s) begin
                rr_last_r <= gnt1_s;
            end else begin
                rr_last_r <= rr_last_r;
            end
            pend_valid_r <= rd_accept_s;
            pend_id_r    <= gnt1_s;
        end
    end

    // Response steering; reset suppresses a response that is still in flight
    always_comb begin
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
        m0_readdatavalid = pend_valid_r & ~pend_id_r & ~reset;
        m1_readdatavalid = pend_valid_r &  pend_id_r & ~reset;
    end

endmodule

// File: tb/tb_nios_project_onchip_mem_arbiter.sv
// Directed bench for the on-chip RAM arbiter: behavioral RAM, shadow memory and response scoreboard.
module tb_nios_project_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset, reset_req;
    logic [12:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic        mem_chipselect, mem_write, mem_clken;

    logic [31:0] ram [0:8191];
    logic [31:0] ref_mem [0:8191];
    logic [32:0] sb_q [$];
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    nios_project_onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // Single-port RAM with byte lanes and one cycle of read latency
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    // One clock: check grant/RAM drive and the response due this cycle, then update the models
    task automatic cycle(input int exp_gnt, input string tag);
        logic [1:0]  exp_wait, exp_rv;
        logic        exp_we;
        logic [32:0] ent;
        #3;
        exp_wait = (exp_gnt == 1) ? 2'b10 : (exp_gnt == 2) ? 2'b01 : 2'b11;
        chk({tag, "/wait"}, 64'({m1_waitrequest, m0_waitrequest}), 64'(exp_wait));
        exp_we = (exp_gnt == 1) ? m0_write : (exp_gnt == 2) ? m1_write : 1'b0;
        chk({tag, "/cs_we"}, 64'({mem_chipselect, mem_write}), 64'({exp_gnt != 0, exp_we}));
        chk({tag, "/clken"}, 64'(mem_clken), 64'(1'b1));
        if (exp_gnt == 1) chk({tag, "/addr"}, 64'(mem_address), 64'(m0_address));
        if (exp_gnt == 2) chk({tag, "/addr"}, 64'(mem_address), 64'(m1_address));
        if (exp_we) chk({tag, "/wdata"}, 64'({mem_byteenable, mem_writedata}),
                        (exp_gnt == 1) ? 64'({m0_byteenable, m0_writedata})
                                       : 64'({m1_byteenable, m1_writedata}));
        if (reset) sb_q.delete();
        if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            exp_rv = ent[32] ? 2'b10 : 2'b01;
            chk({tag, "/rvalid"}, 64'({m1_readdatavalid, m0_readdatavalid}), 64'(exp_rv));
            chk({tag, "/rdata"}, 64'(ent[32] ? m1_readdata : m0_readdata), 64'(ent[31:0]));
        end else begin
            chk({tag, "/rvalid"}, 64'({m1_readdatavalid, m0_readdatavalid}), 64'(2'b00));
        end
        if (exp_gnt == 1 && m0_read && !m0_write) sb_q.push_back({1'b0, ref_mem[m0_address]});
        if (exp_gnt == 2 && m1_read && !m1_write) sb_q.push_back({1'b1, ref_mem[m1_address]});
        @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            if (exp_gnt == 1 && m0_write && m0_byteenable[b])
                ref_mem[m0_address][b*8 +: 8] = m0_writedata[b*8 +: 8];
            if (exp_gnt == 2 && m1_write && m1_byteenable[b])
                ref_mem[m1_address][b*8 +: 8] = m1_writedata[b*8 +: 8];
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            ram[i]     = 32'hCAFE0000 | 32'(i);
            ref_mem[i] = 32'hCAFE0000 | 32'(i);
        end
        reset = 1'b1; reset_req = 1'b0; idle();
        m0_address = 13'h0000; m1_address = 13'h0000;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = 32'h0; m1_writedata = 32'h0;
        @(negedge clk);
        cycle(0, "rst0");
        m0_read = 1'b1; m1_read = 1'b1;
        cycle(0, "rst_req_blk");

        // contention straight after reset: m0, m1, m0, m1
        reset = 1'b0; m0_address = 13'h0020; m1_address = 13'h0030;
        cycle(1, "rr0");
        cycle(2, "rr1");
        cycle(1, "rr2");
        cycle(2, "rr3");
        idle();
        cycle(0, "rr_drain");

        reset = 1'b1;
        cycle(0, "rst1");
        reset = 1'b0; m0_read = 1'b1; m0_address = 13'h0010;
        cycle(1, "rd_single");
        idle();
        cycle(0, "rd_resp");

        // write then read at the top address; read+write together counts as write
        m1_read = 1'b1; m1_write = 1'b1; m1_address = 13'h1FFF; m1_writedata = 32'h12345678;
        m1_byteenable = 4'hF;
        cycle(2, "wr_full");
        idle(); m0_read = 1'b1; m0_address = 13'h1FFF;
        cycle(1, "rd_full");
        idle(); m1_write = 1'b1; m1_writedata = 32'h0000AB00; m1_byteenable = 4'h2;
        cycle(2, "wr_be2");
        idle(); m0_read = 1'b1;
        cycle(1, "rd_be2");
        idle();
        cycle(0, "rd_be2_resp");

        // write/read overlap
        m1_read = 1'b1; m1_address = 13'h0040;
        cycle(2, "ov_rd1");
        m1_address = 13'h0041; m0_write = 1'b1; m0_address = 13'h0050;
        m0_writedata = 32'hA5A5A5A5; m0_byteenable = 4'hF;
        cycle(1, "ov_wr0");
        idle(); m1_read = 1'b1;
        cycle(2, "ov_rd1b");
        idle();
        cycle(0, "ov_drain");
        m0_read = 1'b1; m0_address = 13'h0050;
        cycle(1, "ov_chk_wr");
        idle();
        cycle(0, "ov_chk_resp");

        // reset_req blocks grants but an accepted read still completes
        m0_read = 1'b1; m0_address = 13'h0060;
        cycle(1, "rq_pre");
        reset_req = 1'b1; m1_read = 1'b1; m1_address = 13'h0061;
        cycle(0, "rq_blk0");
        cycle(0, "rq_blk1");
        reset_req = 1'b0; idle();
        cycle(0, "rq_rel");

        // reset the cycle after an m0 accept drops the response and restores m0 priority
        m0_read = 1'b1; m0_address = 13'h0070;
        cycle(1, "rs_pre");
        idle(); reset = 1'b1;
        cycle(0, "rs_drop");
        reset = 1'b0; m0_read = 1'b1; m1_read = 1'b1; m1_address = 13'h0071;
        cycle(1, "rs_rr0");
        cycle(2, "rs_rr1");
        idle();
        cycle(0, "rs_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nios_project_onchip_mem_arbiter.md
# nios_project_onchip_mem_arbiter

Two-requester round-robin arbiter sharing the single-port 8192 x 32 on-chip RAM between the Nios II data master (port m0) and the CRC accelerator's memory master (port m1). It sits between the two Avalon-MM masters and the RAM's s1 port. It issues at most one RAM access per cycle and holds the loser with waitrequest. It steers the 1-cycle-latency read data back to the issuing master with readdatavalid.

## Interface
Parameters:
- ADDR_W, 13, word address width (RAM depth 2^ADDR_W = 8192)
- DATA_W, 32, data width; byteenable width is DATA_W/8

Ports (x = 0, 1):
- clk  in  1  single clock; RAM and both masters share it
- reset  in  1  synchronous, active-high reset
- reset_req  in  1  reset-request from the reset controller; blocks new grants
- mx_address  in  ADDR_W  word address from requester x
- mx_byteenable  in  DATA_W/8  byte lanes for requester x
- mx_read  in  1  read request
- mx_write  in  1  write request
- mx_writedata  in  DATA_W  write data
- mx_waitrequest  out  1  high: request not accepted this cycle
- mx_readdata  out  DATA_W  read data, qualified by mx_readdatavalid
- mx_readdatavalid  out  1  one-cycle pulse with the read response
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  DATA_W/8  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken; constant 1
- mem_readdata  in  DATA_W  from RAM; valid the cycle after the address edge

## Operation
- req_x = mx_read | mx_write. If both read and write are asserted, the request is a write and the read is ignored.
- State: rr_last (1 bit, the last granted requester), pend_valid, pend_id.
- Grant (combinational, same cycle):
  - Only one requester active: it wins.
  - Both active: the requester that is not rr_last wins.
  - Neither active: no grant.
- No grant is issued while reset or reset_req is high.
- Winner: mx_waitrequest = 0, and its address/byteenable/writedata drive mem_*. mem_chipselect = 1. mem_write = winner's write.
- Loser, and any idle requester: mx_waitrequest = 1.
- Idle or blocked cycle: mem_chipselect = 0, mem_write = 0, and mem_address holds the m0 value (don't-care).
- On each accepted transfer, rr_last <= winner at the clock edge.
- Accepted read: pend_valid <= 1 and pend_id <= winner. Otherwise pend_valid <= 0.
- Response (combinational from registered state):
  - mx_readdata = mem_readdata for both ports.
  - mx_readdatavalid = pend_valid & (pend_id == x).
- Writes produce no response.
- Back-to-back reads from either or both masters sustain one transfer per cycle. Responses return in issue order, each exactly 1 cycle after acceptance.
- Reset: rr_last <= 1, so m0 wins the first contention. pend_valid <= 0.
- Reset outputs: all readdatavalid = 0; all waitrequest = 1 while reset is high; mem_chipselect = 0; mem_write = 0.
- reset_req asserted while a read is pending: the response is still delivered next cycle, because the RAM address was already registered.
- reset asserted while a read is pending: the response is dropped (pend_valid cleared).

## Timing
- Accept cycle T: request and waitrequest=0 seen at edge T; the RAM registers the address/write at the same edge.
- Read data: mx_readdatavalid high during cycle T+1, sampled at edge T+1.
- Write: complete at edge T. A same-address read accepted at T+1 returns the new data.
- Loser: keeps its request stable while waitrequest=1. It is granted the next cycle if the winner deasserts or the other requester contends again (round-robin).
- Worst-case wait under continuous contention: 1 cycle.
- Critical path: mx_read/write -> grant -> mem_* and mx_waitrequest. Combinational; no registered grant.

## Test plan
- Reset then single read: m0_read, address 0x0010, RAM preloaded with 0xCAFE0010 -> m0_waitrequest=0 the same cycle; m0_readdatavalid=1 and m0_readdata=0xCAFE0010 the next cycle; m1_readdatavalid stays 0.
- Simultaneous contention right after reset: m0 and m1 both read, held for 4 cycles -> grants m0, m1, m0, m1. Each master's waitrequest is low on alternate cycles; readdatavalid follows each grant by exactly 1 cycle with the matching id.
- Write then read: m1 writes 0x12345678 to 0x1FFF with byteenable 0xF, then m0 reads 0x1FFF -> 0x12345678. Byteenable 0x2 write of 0x0000AB00 -> read returns 0x1234AB78.
- Write/read overlap: m0 writes while m1 reads pending data -> m1 response arrives 1 cycle after its accept. The write produces no readdatavalid.
- reset_req high with both masters requesting -> both waitrequest=1 and mem_chipselect=0. A read accepted the cycle before reset_req rose still returns readdatavalid.
- Reset asserted the cycle after a read accept -> no readdatavalid. rr_last returns to 1, so the next contention grants m0.
